pipe_adder: RTL and testbench
=============================

PIPE_ADDER -- requirements
Module: pipe_adder

Interface
REQ-001 Parameter WIDTH, default 16: operand and sum width in bits.
REQ-002 Parameter CHUNK, default 4: bits added per pipeline stage; WIDTH SHALL be an integer multiple of CHUNK; STAGES = WIDTH/CHUNK.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 in_valid  input  1  operand beat present.
REQ-006 in_ready  output  1  block accepts a beat this cycle.
REQ-007 a  input  WIDTH  operand A, unsigned/two's complement.
REQ-008 b  input  WIDTH  operand B.
REQ-009 cin  input  1  carry-in, add mode only.
REQ-010 sub  input  1  1 = compute a - b; 0 = compute a + b + cin.
REQ-011 out_valid  output  1  result beat present.
REQ-012 out_ready  input  1  downstream accepts the result beat.
REQ-013 s  output  WIDTH  sum/difference.
REQ-014 cout  output  1  carry out of MSB (sub mode: 1 = no borrow).
REQ-015 ovf  output  1  signed two's-complement overflow.

Function
REQ-016 The block SHALL be a STAGES-deep pipeline; stage k adds bits [k*CHUNK+CHUNK-1 : k*CHUNK] plus the carry registered by stage k-1 (stage 0 uses the effective carry-in).
REQ-017 Effective operand B SHALL be b when sub=0 and ~b when sub=1; effective carry-in SHALL be cin when sub=0 and 1 when sub=1 (cin ignored).
REQ-018 Operand bits not yet consumed and sum chunks already produced SHALL be carried forward in stage registers alongside a per-stage valid bit.
REQ-019 A beat SHALL be accepted when in_valid && in_ready; its result SHALL appear with out_valid=1 exactly STAGES cycles later absent stalls.
REQ-020 {cout, s} SHALL equal the (WIDTH+1)-bit result of a + B_eff + carry_eff.
REQ-021 ovf SHALL be 1 iff A[MSB] == B_eff[MSB] and s[MSB] != A[MSB].
REQ-022 Stall = out_valid && !out_ready; during stall every stage register, including valid bits, SHALL hold.
REQ-023 in_ready SHALL equal !stall (combinational); no beat is dropped or duplicated.
REQ-024 Bubbles (in_valid=0 when in_ready=1) SHALL propagate as valid=0 stages; the pipeline SHALL accept one beat per cycle when not stalled.
REQ-025 s, cout, ovf SHALL remain stable while out_valid=1 and out_ready=0.
REQ-026 Results SHALL leave in acceptance order.
REQ-027 a, b, cin, sub SHALL be sampled only on an accepting cycle; values on other cycles have no effect.
REQ-028 Wrap-around: all-ones + 1 SHALL yield s=0, cout=1; no saturation.
REQ-029 CHUNK == WIDTH SHALL be legal (single stage, latency 1).

Reset
REQ-030 While rst=1 at a clock edge, all stage valid bits SHALL clear; out_valid SHALL be 0 the following cycle.
REQ-031 After reset, s, cout, ovf SHALL be 0; data registers SHALL be cleared to 0.
REQ-032 Reset mid-operation SHALL discard all in-flight beats; no stale result SHALL emerge afterwards.
REQ-033 in_ready SHALL be 1 in the first cycle after reset deasserts.

Verification (WIDTH=16, CHUNK=4, STAGES=4)
REQ-034 Single add: a=0x1234, b=0x0FFF, cin=1, sub=0, out_ready=1 -> 4 cycles later out_valid=1, s=0x2234, cout=0, ovf=0.
REQ-035 Carry chain: a=0xFFFF, b=0x0000, cin=1 -> s=0x0000, cout=1, ovf=0; a=0x7FFF, b=0x0001, cin=0 -> s=0x8000, cout=0, ovf=1.
REQ-036 Subtract: a=0x0005, b=0x0007, sub=1, cin=1 -> s=0xFFFE, cout=0, ovf=0; a=0x8000, b=0x0001, sub=1 -> s=0x7FFF, cout=1, ovf=1.
REQ-037 Backpressure: stream 6 back-to-back beats, hold out_ready=0 for 3 cycles after first result -> in_ready=0 those cycles, output held stable, all 6 results delivered in order, none lost.
REQ-038 Reset mid-flight: accept 3 beats, assert rst one cycle -> out_valid stays 0 until new beats enter; new beat a=0x0001, b=0x0001 -> s=0x0002 after 4 cycles.
REQ-039 Random: 10k beats with random in_valid/out_ready, scoreboard against WIDTH+1-bit reference add/sub -> zero mismatches, for CHUNK in {1,4,8,16}.

Source files
------------

// File: rtl/pipe_adder.sv
// Chunked ripple-pipelined adder/subtractor with valid/ready handshake.
// Each stage adds one CHUNK-wide slice of the operands plus the carry
// produced by the previous stage, so the long carry chain is broken into
// STAGES short ones. The whole pipeline advances together and freezes as
// one unit while the output beat is held by downstream backpressure.
module pipe_adder #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic             ovf
);

    // WIDTH must be a whole multiple of CHUNK; CHUNK == WIDTH gives a
    // single-stage, latency-1 adder.
    localparam int STAGES = WIDTH / CHUNK;
    localparam int LAST   = STAGES - 1;

    // One slice of the addition, carry returned in the top bit.
    function automatic logic [CHUNK:0] add_chunk(
        input logic [CHUNK-1:0] x,
        input logic [CHUNK-1:0] y,
        input logic             c
    );
        return {1'b0, x} + {1'b0, y} + {{CHUNK{1'b0}}, c};
    endfunction

    // Stage register outputs, one element per stage.
    logic [WIDTH-1:0] a_p     [STAGES];
    logic [WIDTH-1:0] b_p     [STAGES];
    logic [WIDTH-1:0] sum_p   [STAGES];
    logic             carry_p [STAGES];
    logic             vld_p   [STAGES];

    logic [WIDTH-1:0] b_eff;
    logic             c_eff;
    logic             stall;

    // Subtraction is a + ~b + 1; cin only matters in add mode.
    assign b_eff = sub ? ~b : b;
    assign c_eff = sub ? 1'b1 : cin;

    // A held output beat freezes every stage, so nothing can be accepted.
    assign stall    = vld_p[LAST] && !out_ready;
    assign in_ready = !stall;

    assign out_valid = vld_p[LAST];
    assign s         = sum_p[LAST];
    assign cout      = carry_p[LAST];
    // Signed overflow: operands agree in sign but the result does not.
    // The last stage still carries the operand MSBs, and all three terms
    // are registered, so the flag is stable while the beat is held.
    assign ovf = (a_p[LAST][WIDTH-1] == b_p[LAST][WIDTH-1]) &&
                 (sum_p[LAST][WIDTH-1] != a_p[LAST][WIDTH-1]);

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic [WIDTH-1:0] a_in;
        logic [WIDTH-1:0] b_in;
        logic [WIDTH-1:0] sum_in;
        logic             c_in;
        logic             v_in;
        logic [CHUNK:0]   res;
        logic [WIDTH-1:0] sum_next;

        logic [WIDTH-1:0] a_r;
        logic [WIDTH-1:0] b_r;
        logic [WIDTH-1:0] sum_r;
        logic             carry_r;
        logic             vld_r;

        if (k == 0) begin : g_first
            // Stage 0 takes the handshake inputs directly; a bubble
            // (in_valid=0) enters as an invalid stage.
            assign a_in   = a;
            assign b_in   = b_eff;
            assign c_in   = c_eff;
            assign sum_in = '0;
            assign v_in   = in_valid;
        end else begin : g_next
            assign a_in   = a_p[k-1];
            assign b_in   = b_p[k-1];
            assign c_in   = carry_p[k-1];
            assign sum_in = sum_p[k-1];
            assign v_in   = vld_p[k-1];
        end

        assign res = add_chunk(a_in[k*CHUNK +: CHUNK], b_in[k*CHUNK +: CHUNK], c_in);

        // Insert this stage's slice into the partially built sum.
        always_comb begin
            sum_next                    = sum_in;
            sum_next[k*CHUNK +: CHUNK]  = res[CHUNK-1:0];
        end

        // Stage register: cleared by reset, held during stall.
        always_ff @(posedge clk) begin
            if (rst) begin
                vld_r   <= 1'b0;
                a_r     <= '0;
                b_r     <= '0;
                sum_r   <= '0;
                carry_r <= 1'b0;
            end else if (!stall) begin
                vld_r   <= v_in;
                a_r     <= a_in;
                b_r     <= b_in;
                sum_r   <= sum_next;
                carry_r <= res[CHUNK];
            end
        end

        assign a_p[k]     = a_r;
        assign b_p[k]     = b_r;
        assign sum_p[k]   = sum_r;
        assign carry_p[k] = carry_r;
        assign vld_p[k]   = vld_r;
    end

endmodule

// File: tb/tb_pipe_adder.sv
// Bench for pipe_adder: directed cases on a CHUNK=4 instance plus a random
// scoreboard run on CHUNK = 4, 1, 8 and 16 instances side by side.
module tb_pipe_adder;

    localparam int W  = 16;
    localparam int NI = 4;
    localparam int NR = 10000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst;
    logic         vi [NI];
    logic         ri [NI];
    logic         vo [NI];
    logic         ro [NI];
    logic         ci [NI];
    logic         sb [NI];
    logic         co [NI];
    logic         ov [NI];
    logic [W-1:0] ta [NI];
    logic [W-1:0] tbv[NI];
    logic [W-1:0] so [NI];

    int total = 0;
    int bad   = 0;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        localparam int CH = (g == 0) ? 4 : (g == 1) ? 1 : (g == 2) ? 8 : 16;
        pipe_adder #(.WIDTH(W), .CHUNK(CH)) dut (
            .clk      (clk),
            .rst      (rst),
            .in_valid (vi[g]),
            .in_ready (ri[g]),
            .a        (ta[g]),
            .b        (tbv[g]),
            .cin      (ci[g]),
            .sub      (sb[g]),
            .out_valid(vo[g]),
            .out_ready(ro[g]),
            .s        (so[g]),
            .cout     (co[g]),
            .ovf      (ov[g])
        );
    end

    // Reference: integer arithmetic, result packed as {ovf, cout, s}.
    function automatic logic [17:0] model(input logic [15:0] x, input logic [15:0] y,
                                          input logic c, input logic m);
        int ux, uy, sx, sy, ur, sr;
        logic cr, vr;
        ux = int'(x);
        uy = int'(y);
        sx = int'($signed(x));
        sy = int'($signed(y));
        if (m) begin
            ur = ux - uy;
            cr = (ux >= uy);
            sr = sx - sy;
        end else begin
            ur = ux + uy + int'(c);
            cr = (ur > 65535);
            sr = sx + sy + int'(c);
        end
        vr = (sr > 32767) || (sr < -32768);
        return {vr, cr, ur[15:0]};
    endfunction

    function automatic logic [15:0] pick_operand();
        case ($urandom_range(0, 7))
            0:       return 16'hFFFF;
            1:       return 16'h7FFF;
            2:       return 16'h8000;
            3:       return 16'h0000;
            default: return 16'($urandom);
        endcase
    endfunction

    task automatic idle_all();
        for (int i = 0; i < NI; i++) begin
            vi[i]  = 1'b0;
            ro[i]  = 1'b1;
            ta[i]  = '0;
            tbv[i] = '0;
            ci[i]  = 1'b0;
            sb[i]  = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst    = 1'b1;
        vi[0]  = 1'b1;
        ta[0]  = 16'hABCD;
        tbv[0] = 16'h1357;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst   = 1'b0;
        vi[0] = 1'b0;
        ro[0] = 1'b0;
        #1;
        for (int i = 0; i < NI; i++) begin
            total++;
            if (vo[i] !== 1'b0) begin
                bad++;
                $display("FAIL reset_out_valid inst=%0d got=%b exp=0", i, vo[i]);
            end
        end
        total++;
        if (so[0] !== 16'h0) begin
            bad++;
            $display("FAIL reset_s got=%h exp=0000", so[0]);
        end
        total++;
        if (co[0] !== 1'b0 || ov[0] !== 1'b0) begin
            bad++;
            $display("FAIL reset_flags got cout=%b ovf=%b exp 0 0", co[0], ov[0]);
        end
        total++;
        if (ri[0] !== 1'b1) begin
            bad++;
            $display("FAIL reset_in_ready got=%b exp=1", ri[0]);
        end
        ro[0] = 1'b1;
    endtask

    task automatic test_directed();
        logic [15:0] va [5] = '{16'h1234, 16'hFFFF, 16'h7FFF, 16'h0005, 16'h8000};
        logic [15:0] vb [5] = '{16'h0FFF, 16'h0000, 16'h0001, 16'h0007, 16'h0001};
        logic        vc [5] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        logic        vs [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        logic [17:0] ve [5] = '{{2'b00, 16'h2234}, {2'b01, 16'h0000}, {2'b10, 16'h8000},
                                {2'b00, 16'hFFFE}, {2'b11, 16'h7FFF}};
        for (int n = 0; n < 5; n++) begin
            int lat;
            @(negedge clk);
            vi[0]  = 1'b1;
            ta[0]  = va[n];
            tbv[0] = vb[n];
            ci[0]  = vc[n];
            sb[0]  = vs[n];
            ro[0]  = 1'b1;
            #1;
            total++;
            if (ri[0] !== 1'b1) begin
                bad++;
                $display("FAIL directed_accept case=%0d in_ready=%b exp=1", n, ri[0]);
            end
            lat = 0;
            for (int c = 1; c <= 20 && lat == 0; c++) begin
                @(negedge clk);
                vi[0]  = 1'b0;
                ta[0]  = 16'($urandom);
                tbv[0] = 16'($urandom);
                ci[0]  = 1'($urandom);
                sb[0]  = 1'($urandom);
                #1;
                if (vo[0] === 1'b1) lat = c;
            end
            total++;
            if (lat != 4) begin
                bad++;
                $display("FAIL directed_latency case=%0d got=%0d exp=4", n, lat);
            end
            total++;
            if ({ov[0], co[0], so[0]} !== ve[n]) begin
                bad++;
                $display("FAIL directed_result case=%0d got ovf=%b cout=%b s=%h exp ovf=%b cout=%b s=%h",
                         n, ov[0], co[0], so[0], ve[n][17], ve[n][16], ve[n][15:0]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [17:0] q[$];
        int sent = 0;
        int got  = 0;
        for (int cyc = 0; cyc < 50 && got < 6; cyc++) begin
            logic hold;
            hold = (cyc >= 4 && cyc <= 6);
            @(negedge clk);
            ro[0] = !hold;
            if (sent < 6) begin
                vi[0]  = 1'b1;
                ta[0]  = pick_operand();
                tbv[0] = pick_operand();
                ci[0]  = 1'($urandom);
                sb[0]  = 1'($urandom);
            end else begin
                vi[0] = 1'b0;
            end
            #1;
            if (hold) begin
                total++;
                if (vo[0] !== 1'b1 || ri[0] !== 1'b0) begin
                    bad++;
                    $display("FAIL stall_handshake cyc=%0d out_valid=%b in_ready=%b exp 1 0",
                             cyc, vo[0], ri[0]);
                end
                total++;
                if (q.size() == 0 || {ov[0], co[0], so[0]} !== q[0]) begin
                    bad++;
                    $display("FAIL stall_hold cyc=%0d got=%h exp=%h", cyc,
                             {ov[0], co[0], so[0]}, (q.size() != 0) ? q[0] : 18'h0);
                end
            end
            if (vi[0] && ri[0]) begin
                q.push_back(model(ta[0], tbv[0], ci[0], sb[0]));
                sent++;
            end
            if (vo[0] && ro[0]) begin
                total++;
                if (q.size() == 0) begin
                    bad++;
                    $display("FAIL b2b_extra got=%h exp=none", {ov[0], co[0], so[0]});
                end else begin
                    logic [17:0] e;
                    e = q.pop_front();
                    if ({ov[0], co[0], so[0]} !== e) begin
                        bad++;
                        $display("FAIL b2b_result idx=%0d got=%h exp=%h", got,
                                 {ov[0], co[0], so[0]}, e);
                    end
                end
                got++;
            end
        end
        vi[0] = 1'b0;
        ro[0] = 1'b1;
        total++;
        if (got != 6 || sent != 6) begin
            bad++;
            $display("FAIL b2b_count got=%0d sent=%0d exp 6 6", got, sent);
        end
    endtask

    task automatic test_mid_reset();
        int lat;
        for (int n = 0; n < 3; n++) begin
            @(negedge clk);
            vi[0]  = 1'b1;
            ta[0]  = 16'h1111 * 16'(n + 1);
            tbv[0] = 16'h0101;
            ci[0]  = 1'b0;
            sb[0]  = 1'b0;
            ro[0]  = 1'b1;
        end
        @(negedge clk);
        vi[0]  = 1'b0;
        ta[0]  = 16'hFFFF;
        tbv[0] = 16'hFFFF;
        rst    = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        total++;
        if (so[0] !== 16'h0 || co[0] !== 1'b0 || ov[0] !== 1'b0) begin
            bad++;
            $display("FAIL midreset_clear got s=%h cout=%b ovf=%b exp 0000 0 0", so[0], co[0], ov[0]);
        end
        for (int c = 0; c < 6; c++) begin
            total++;
            if (vo[0] !== 1'b0) begin
                bad++;
                $display("FAIL midreset_stale cyc=%0d out_valid=%b exp=0", c, vo[0]);
            end
            @(negedge clk);
            #1;
        end
        @(negedge clk);
        vi[0]  = 1'b1;
        ta[0]  = 16'h0001;
        tbv[0] = 16'h0001;
        ci[0]  = 1'b0;
        sb[0]  = 1'b0;
        lat = 0;
        for (int c = 1; c <= 20 && lat == 0; c++) begin
            @(negedge clk);
            vi[0] = 1'b0;
            #1;
            if (vo[0] === 1'b1) lat = c;
        end
        total++;
        if (lat != 4 || so[0] !== 16'h0002) begin
            bad++;
            $display("FAIL midreset_new latency=%0d s=%h exp 4 0002", lat, so[0]);
        end
    endtask

    task automatic test_random();
        logic [17:0] eq [NI][64];
        int sent[NI], got[NI], wr[NI], rd[NI];
        int cyc;
        logic done;
        for (int i = 0; i < NI; i++) begin
            sent[i] = 0;
            got[i]  = 0;
            wr[i]   = 0;
            rd[i]   = 0;
        end
        cyc  = 0;
        done = 1'b0;
        while (!done && cyc < 60000) begin
            @(negedge clk);
            for (int i = 0; i < NI; i++) begin
                ro[i]  = ($urandom_range(0, 3) != 0);
                vi[i]  = (sent[i] < NR) && ($urandom_range(0, 3) != 0);
                ta[i]  = pick_operand();
                tbv[i] = pick_operand();
                ci[i]  = 1'($urandom);
                sb[i]  = 1'($urandom);
            end
            #1;
            done = 1'b1;
            for (int i = 0; i < NI; i++) begin
                total++;
                if (ri[i] !== !(vo[i] && !ro[i])) begin
                    bad++;
                    $display("FAIL rand_in_ready inst=%0d cyc=%0d got=%b exp=%b",
                             i, cyc, ri[i], !(vo[i] && !ro[i]));
                end
                if (vi[i] && ri[i]) begin
                    eq[i][wr[i] % 64] = model(ta[i], tbv[i], ci[i], sb[i]);
                    wr[i]++;
                    sent[i]++;
                end
                if (vo[i] && ro[i]) begin
                    total++;
                    if (rd[i] == wr[i]) begin
                        bad++;
                        $display("FAIL rand_extra inst=%0d got=%h exp=none", i, {ov[i], co[i], so[i]});
                    end else begin
                        if ({ov[i], co[i], so[i]} !== eq[i][rd[i] % 64]) begin
                            bad++;
                            $display("FAIL rand_result inst=%0d idx=%0d got=%h exp=%h",
                                     i, got[i], {ov[i], co[i], so[i]}, eq[i][rd[i] % 64]);
                        end
                        rd[i]++;
                    end
                    got[i]++;
                end
                if (got[i] < NR) done = 1'b0;
            end
            cyc++;
        end
        idle_all();
        for (int i = 0; i < NI; i++) begin
            total++;
            if (got[i] != NR) begin
                bad++;
                $display("FAIL rand_count inst=%0d got=%0d exp=%0d", i, got[i], NR);
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        idle_all();
        test_reset();
        test_directed();
        test_back_to_back();
        test_mid_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
